// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART constants and types used by the transmit scheduler and the
// receive control logic: frame-state encoding, data/stop bit counts and a
// small helper that decides whether a state drives a frame onto the line.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  // True for every state in which a frame occupies the serial line.
  function automatic logic uart_line_active(input uart_state_e st);
    logic active;
    case (st)
      UART_IDLE:  active = 1'b0;
      UART_START: active = 1'b1;
      UART_DATA:  active = 1'b1;
      UART_STOP:  active = 1'b1;
      default:    active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
// Bundle between NUM_REQ byte requesters and the shared UART transmitter.
//   req_valid  : bit i set while requester i holds a byte
//   req_data   : byte i at [8i+7:8i], stable until accepted
//   req_ready  : one-hot accept strobe, combinational
//   tx         : serial line, idle high
//   busy       : a frame is on the line
//   grant_id   : requester owning the current frame
//   frame_done : one-cycle pulse on the last cycle of each stop bit
// master = requester side, slave = scheduler side.
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              tx;
  logic                              busy;
  logic [ID_W-1:0]                   grant_id;
  logic                              frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx, busy, grant_id, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx, busy, grant_id, frame_done
  );

endinterface

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter
// 8N1 frame generator: baud counter, shift register, frame FSM and a
// registered tx/busy drive.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : take load_data now (only honoured while accept is high)
//   load_data  : byte to transmit, LSB first
//   accept     : a new byte may be loaded this cycle (idle, or final stop cycle)
//   frame_done : last cycle of the final stop bit
//   tx, busy   : registered serial line and line-occupied flag
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] load_data,
  output logic                      accept,
  output logic                      frame_done,
  output logic                      tx,
  output logic                      busy
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(UART_STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_end_s;
  logic                      last_stop_s;

  // Bit-period boundary and the handshake window derived from it.
  always_comb begin
    bit_end_s   = 1'b0;
    last_stop_s = 1'b0;
    accept      = 1'b0;
    frame_done  = 1'b0;
    if (state_q != UART_IDLE) begin
      bit_end_s = (bit_cnt_q == CNT_LAST);
    end else begin
      bit_end_s = 1'b0;
    end
    last_stop_s = (state_q == UART_STOP) && bit_end_s && (bit_idx_q == STOP_LAST);
    frame_done  = last_stop_s;
    // A new byte is only taken once the stop bit has fully elapsed.
    accept      = (state_q == UART_IDLE) || last_stop_s;
  end

  // Frame FSM next state, baud counter, bit index and shift register.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    // Counter restarts at every bit boundary, which covers every state change.
    if ((state_q == UART_IDLE) || bit_end_s) begin
      bit_cnt_d = {CNT_W{1'b0}};
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      UART_IDLE: begin
        if (load) begin
          state_d   = UART_START;
          shift_d   = load_data;
          bit_idx_d = {IDX_W{1'b0}};
        end else begin
          state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (bit_end_s) begin
          state_d   = UART_DATA;
          bit_idx_d = {IDX_W{1'b0}};
        end else begin
          state_d = UART_START;
        end
      end
      UART_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == DATA_LAST) begin
            state_d   = UART_STOP;
            bit_idx_d = {IDX_W{1'b0}};
          end else begin
            state_d   = UART_DATA;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          state_d = UART_DATA;
        end
      end
      UART_STOP: begin
        if (last_stop_s) begin
          bit_idx_d = {IDX_W{1'b0}};
          if (load) begin
            state_d = UART_START;
            shift_d = load_data;
          end else begin
            state_d = UART_IDLE;
          end
        end else if (bit_end_s) begin
          state_d   = UART_STOP;
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          state_d = UART_STOP;
        end
      end
      default: begin
        state_d   = UART_IDLE;
        bit_cnt_d = {CNT_W{1'b0}};
        bit_idx_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Line level follows the upcoming state so tx changes on the same edge as the FSM.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = uart_line_active(state_d);
    case (state_d)
      UART_IDLE:  tx_d = 1'b1;
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      UART_STOP:  tx_d = 1'b1;
      default:    tx_d = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UART_IDLE;
      bit_cnt_q <= {CNT_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {UART_DATA_BITS{1'b0}};
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART tx line among NUM_REQ byte requesters. A round-robin
// arbiter picks the next requester whenever the shifter can take a byte,
// strobes its req_ready for that single cycle and hands the byte to
// uart_tx_shifter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshake plus tx/busy/grant_id/frame_done
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]           grant_id_q, grant_id_d;
  logic [ID_W-1:0]           winner_s;
  logic [ID_W:0]             cand_sum_s;
  logic [ID_W-1:0]           cand_s;
  logic                      found_s;
  logic                      accept_s;
  logic                      frame_done_s;
  logic                      load_s;
  logic [NUM_REQ-1:0]        ready_s;
  logic [UART_DATA_BITS-1:0] load_data_s;
  logic                      tx_s;
  logic                      busy_s;

  // Cyclic first-set search over req_valid starting at rr_ptr.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = {ID_W{1'b0}};
    cand_sum_s = {(ID_W+1){1'b0}};
    cand_s     = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand_sum_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum_s = cand_sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_s = cand_sum_s[ID_W-1:0];
      if (!found_s && bus.req_valid[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant strobe, byte mux and pointer/grant updates for an accept cycle.
  always_comb begin
    // Held reset must not strobe ready even though the shifter sits in IDLE.
    load_s      = accept_s && found_s && !rst;
    load_data_s = bus.req_data[{winner_s, 3'b000} +: UART_DATA_BITS];
    ready_s     = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      ready_s[k] = load_s && (winner_s == ID_W'(k));
    end
    if (load_s) begin
      grant_id_d = winner_s;
      if (winner_s == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_d = {ID_W{1'b0}};
      end else begin
        rr_ptr_d = winner_s + ID_W'(1);
      end
    end else begin
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= {ID_W{1'b0}};
      grant_id_q <= {ID_W{1'b0}};
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  uart_tx_shifter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_data  (load_data_s),
    .accept     (accept_s),
    .frame_done (frame_done_s),
    .tx         (tx_s),
    .busy       (busy_s)
  );

  assign bus.req_ready  = ready_s;
  assign bus.tx         = tx_s;
  assign bus.busy       = busy_s;
  assign bus.grant_id   = grant_id_q;
  assign bus.frame_done = frame_done_s;

endmodule
